// File: rtl/decode_stage_pipelined.sv
// -----------------------------------------------------------------------------
// decode_stage_pipelined
//
// Instruction-decode stage sitting between the IF/ID register and execute.
// Contains the register file, two-level operand forwarding (EX/MEM result,
// then same-cycle writeback bypass), branch resolution in ID, a load-use
// interlock of LOAD_USE_STALL cycles and the ID/EX pipeline register.
// Both sides use valid/ready handshakes.
//
// Ports
//   Clk, Reset                  clock (rising edge), asynchronous active-low reset
//   InValid / InReady           upstream handshake (instruction held in IF/ID)
//   Instruction, PCResult       instruction word and its PC
//   CtrlIn                      Controller control word, passed through
//   IsBranch, BrCond            conditional branch flag and condition code
//   Flush                       discard the instruction currently in ID
//   ExMemRead, ExRd             load in EX and its destination (interlock)
//   ExFwdValid/Reg/Data         EX/MEM forwarding source
//   WbWrite/Reg/Data            register file write port
//   OutReady / OutValid         downstream handshake (ID/EX register)
//   OutData1/2, OutImm, OutPC   registered operands, extended immediate, PC
//   OutRs, OutRt, OutRd         registered register fields
//   OutCtrl                     registered control word (0 on bubbles)
//   BranchTaken, BranchAddress  combinational redirect request and target
//
// Optional build macro DECODE_DEBUG_EN adds:
//   v0, v1        register 2 / 3 contents with writeback bypass applied
//   StallCycles   saturating count of cycles in which the stage stalled
// -----------------------------------------------------------------------------
module decode_stage_pipelined #(
  parameter int XLEN           = 32,
  parameter int REG_COUNT      = 32,
  parameter int CTRL_WIDTH     = 20,
  parameter int LOAD_USE_STALL = 1,
  localparam int RIW           = $clog2(REG_COUNT)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [31:0]           Instruction,
  input  logic [XLEN-1:0]       PCResult,
  input  logic [CTRL_WIDTH-1:0] CtrlIn,
  input  logic                  IsBranch,
  input  logic [2:0]            BrCond,
  input  logic                  Flush,
  input  logic                  ExMemRead,
  input  logic [RIW-1:0]        ExRd,
  input  logic                  ExFwdValid,
  input  logic [RIW-1:0]        ExFwdReg,
  input  logic [XLEN-1:0]       ExFwdData,
  input  logic                  WbWrite,
  input  logic [RIW-1:0]        WbReg,
  input  logic [XLEN-1:0]       WbData,
  input  logic                  OutReady,
  output logic                  OutValid,
  output logic [XLEN-1:0]       OutData1,
  output logic [XLEN-1:0]       OutData2,
  output logic [XLEN-1:0]       OutImm,
  output logic [XLEN-1:0]       OutPC,
  output logic [RIW-1:0]        OutRs,
  output logic [RIW-1:0]        OutRt,
  output logic [RIW-1:0]        OutRd,
  output logic [CTRL_WIDTH-1:0] OutCtrl,
`ifdef DECODE_DEBUG_EN
  output logic [XLEN-1:0]       v0,
  output logic [XLEN-1:0]       v1,
  output logic [31:0]           StallCycles,
`endif
  output logic                  BranchTaken,
  output logic [XLEN-1:0]       BranchAddress
);

  // Register indices are compared at the wider of the 5-bit instruction
  // field and the parameterised index width so neither side is truncated.
  localparam int FW   = (RIW > 5) ? RIW : 5;
  localparam int CNTW = $clog2(LOAD_USE_STALL + 1);

  // ---------------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------------
  logic [5:0]    opcode;
  logic [FW-1:0] rs_idx;
  logic [FW-1:0] rt_idx;
  logic [FW-1:0] ex_rd_idx;
  logic [FW-1:0] ex_fwd_idx;
  logic [FW-1:0] wb_idx;

  assign opcode     = Instruction[31:26];
  assign rs_idx     = FW'(Instruction[25:21]);
  assign rt_idx     = FW'(Instruction[20:16]);
  assign ex_rd_idx  = FW'(ExRd);
  assign ex_fwd_idx = FW'(ExFwdReg);
  assign wb_idx     = FW'(WbReg);

  // ---------------------------------------------------------------------------
  // Register file. Cleared by reset, so it is built from flops rather than
  // block RAM. Entry 0 is never written and is additionally masked on read.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs [REG_COUNT];
  logic            wb_en;

  assign wb_en = WbWrite && (wb_idx != '0) &&
                 ({1'b0, wb_idx} < (FW+1)'(REG_COUNT));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[WbReg] <= WbData;
    end
  end

  // Raw register-file reads; out-of-range and r0 read as zero.
  logic [XLEN-1:0] rf_rs;
  logic [XLEN-1:0] rf_rt;

  always_comb begin
    rf_rs = '0;
    rf_rt = '0;
    if (rs_idx != '0 && ({1'b0, rs_idx} < (FW+1)'(REG_COUNT))) begin
      rf_rs = regs[rs_idx[RIW-1:0]];
    end
    if (rt_idx != '0 && ({1'b0, rt_idx} < (FW+1)'(REG_COUNT))) begin
      rf_rt = regs[rt_idx[RIW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding: EX/MEM result has priority over the writeback bypass,
  // which in turn beats the stored value. r0 is never forwarded.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  always_comb begin
    op_a = rf_rs;
    if (ExFwdValid && ex_fwd_idx == rs_idx && rs_idx != '0) begin
      op_a = ExFwdData;
    end else if (WbWrite && wb_idx == rs_idx && rs_idx != '0) begin
      op_a = WbData;
    end

    op_b = rf_rt;
    if (ExFwdValid && ex_fwd_idx == rt_idx && rt_idx != '0) begin
      op_b = ExFwdData;
    end else if (WbWrite && wb_idx == rt_idx && rt_idx != '0) begin
      op_b = WbData;
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate: logical-immediate opcodes (andi/ori/xori) zero-extend.
  // ---------------------------------------------------------------------------
  logic            zero_ext;
  logic [XLEN-1:0] imm_ext;

  assign zero_ext = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
  assign imm_ext  = zero_ext ? XLEN'(Instruction[15:0])
                             : {{(XLEN-16){Instruction[15]}}, Instruction[15:0]};

  // ---------------------------------------------------------------------------
  // Branch resolution on the forwarded operands.
  // ---------------------------------------------------------------------------
  logic a_neg;
  logic a_zero;
  logic br_cond;

  assign a_neg  = op_a[XLEN-1];
  assign a_zero = (op_a == '0);

  always_comb begin
    br_cond = 1'b0;
    case (BrCond)
      3'b000:  br_cond = (op_a == op_b);        // beq
      3'b001:  br_cond = (op_a != op_b);        // bne
      3'b010:  br_cond = !a_neg;                // bgez
      3'b011:  br_cond = !a_neg && !a_zero;     // bgtz
      3'b100:  br_cond = a_neg || a_zero;       // blez
      3'b101:  br_cond = a_neg;                 // bltz
      default: br_cond = 1'b0;
    endcase
  end

  assign BranchAddress = PCResult + XLEN'(4) + (imm_ext << 2);

  // ---------------------------------------------------------------------------
  // Load-use interlock. cnt holds the remaining stall cycles after the one in
  // which the hazard is first seen, so a hazard costs LOAD_USE_STALL cycles.
  // Flush wins over everything: the instruction is being discarded, so there
  // is nothing left to wait for.
  // ---------------------------------------------------------------------------
  logic [CNTW-1:0] cnt_reg;
  logic [CNTW-1:0] cnt_next;
  logic            hazard_new;
  logic            stall;

  assign hazard_new = InValid && ExMemRead && (ex_rd_idx != '0) &&
                      ((ex_rd_idx == rs_idx) || (ex_rd_idx == rt_idx)) &&
                      (cnt_reg == '0);
  assign stall      = (hazard_new || (cnt_reg != '0)) && !Flush;

  always_comb begin
    cnt_next = cnt_reg;
    if (Flush) begin
      cnt_next = '0;
    end else if (hazard_new) begin
      cnt_next = CNTW'(LOAD_USE_STALL - 1);
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and redirect
  // ---------------------------------------------------------------------------
  logic out_valid_reg;
  logic idex_load;
  logic id_valid;

  assign idex_load   = OutReady || !out_valid_reg;
  assign InReady     = !stall && idex_load;
  assign id_valid    = InValid && !stall && !Flush;
  assign BranchTaken = InValid && IsBranch && br_cond && InReady && !Flush;

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register. Data fields load on every open slot; only the
  // control word is forced to zero for bubbles, OutValid qualifies the rest.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]       out_data1_reg;
  logic [XLEN-1:0]       out_data2_reg;
  logic [XLEN-1:0]       out_imm_reg;
  logic [XLEN-1:0]       out_pc_reg;
  logic [RIW-1:0]        out_rs_reg;
  logic [RIW-1:0]        out_rt_reg;
  logic [RIW-1:0]        out_rd_reg;
  logic [CTRL_WIDTH-1:0] out_ctrl_reg;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out_valid_reg <= 1'b0;
      out_data1_reg <= '0;
      out_data2_reg <= '0;
      out_imm_reg   <= '0;
      out_pc_reg    <= '0;
      out_rs_reg    <= '0;
      out_rt_reg    <= '0;
      out_rd_reg    <= '0;
      out_ctrl_reg  <= '0;
    end else if (idex_load) begin
      out_valid_reg <= id_valid;
      out_data1_reg <= op_a;
      out_data2_reg <= op_b;
      out_imm_reg   <= imm_ext;
      out_pc_reg    <= PCResult;
      out_rs_reg    <= RIW'(Instruction[25:21]);
      out_rt_reg    <= RIW'(Instruction[20:16]);
      out_rd_reg    <= RIW'(Instruction[15:11]);
      out_ctrl_reg  <= id_valid ? CtrlIn : '0;
    end
  end

  assign OutValid = out_valid_reg;
  assign OutData1 = out_data1_reg;
  assign OutData2 = out_data2_reg;
  assign OutImm   = out_imm_reg;
  assign OutPC    = out_pc_reg;
  assign OutRs    = out_rs_reg;
  assign OutRt    = out_rt_reg;
  assign OutRd    = out_rd_reg;
  assign OutCtrl  = out_ctrl_reg;

`ifdef DECODE_DEBUG_EN
  // ---------------------------------------------------------------------------
  // Debug visibility: registers 2/3 with the writeback bypass applied, and a
  // saturating stall-cycle counter.
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cycles_reg;

  assign v0 = (wb_en && wb_idx == FW'(2)) ? WbData : regs[2];
  assign v1 = (wb_en && wb_idx == FW'(3)) ? WbData : regs[3];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cycles_reg <= '0;
    end else if (stall && (stall_cycles_reg != '1)) begin
      stall_cycles_reg <= stall_cycles_reg + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_reg;
`endif

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised next-generation instruction-decode stage.
- Integrates the register file, operand forwarding, in-stage branch resolution, load-use hazard interlock and an ID/EX pipeline register.
- Sits between the IF/ID register and the execute stage, with valid/ready handshakes on both sides.
- Takes its control word from the existing Controller and passes it through, zeroed on bubbles.

Parameters:
- XLEN, 32, datapath and PC width.
- REG_COUNT, 32, number of architectural registers; register index width is clog2(REG_COUNT).
- CTRL_WIDTH, 20, width of the pass-through control word.
- LOAD_USE_STALL, 1, number of stall cycles inserted per load-use hazard (≥1).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- InValid  in  1  IF/ID holds a valid instruction.
- InReady  out  1  stage accepts the instruction this cycle.
- Instruction  in  32  instruction word.
- PCResult  in  XLEN  PC of the instruction.
- CtrlIn  in  CTRL_WIDTH  control word from Controller.
- IsBranch  in  1  instruction is a conditional branch.
- BrCond  in  3  000 beq, 001 bne, 010 bgez, 011 bgtz, 100 blez, 101 bltz.
- Flush  in  1  discard the instruction currently in ID.
- ExMemRead, ExRd  in  1, RIW  load in EX and its destination.
- ExFwdValid, ExFwdReg, ExFwdData  in  1, RIW, XLEN  EX/MEM result available for forwarding.
- WbWrite, WbReg, WbData  in  1, RIW, XLEN  writeback port.
- OutReady  in  1  EX accepts.
- OutValid  out  1  ID/EX holds a valid instruction.
- OutData1, OutData2, OutImm, OutPC  out  XLEN each  registered operands, extended immediate, PC.
- OutRs, OutRt, OutRd  out  RIW each  registered register fields.
- OutCtrl  out  CTRL_WIDTH  registered control word.
- BranchTaken  out  1  combinational redirect request.
- BranchAddress  out  XLEN  combinational branch target.

Behaviour:
- Reset (asynchronous, active-low):
  - All ID/EX outputs are 0, including OutValid.
  - All registers in the file are 0.
  - The stall counter is 0.
- Register file:
  - rs = Instruction[25:21], rt = Instruction[20:16]; indices at or above REG_COUNT read 0.
  - Register 0 always reads 0; writes to register 0 are ignored.
  - WbWrite writes WbData at the rising edge.
- Operand select, per source, in priority order:
  1. ExFwdValid && ExFwdReg == src && src != 0 → ExFwdData.
  2. WbWrite && WbReg == src && src != 0 → WbData (same-cycle write-through).
  3. Otherwise the register-file value.
- Immediate:
  - Opcodes 0x0C, 0x0D, 0x0E zero-extend Instruction[15:0].
  - All other opcodes sign-extend Instruction[15:0] to XLEN.
- Branch:
  - BranchAddress = PCResult + 4 + (OutImm-source << 2), modulo 2^XLEN.
  - Comparison uses the forwarded operands; sign tests treat the rs operand as signed.
  - Unknown BrCond codes compare false.
  - BranchTaken = InValid & IsBranch & cond & InReady & !Flush; zero-latency, in the accept cycle.
- Hazard:
  - hazard_new = InValid & ExMemRead & ExRd != 0 & (ExRd == rs | ExRd == rt) & cnt == 0.
  - stall = hazard_new | cnt != 0.
  - On hazard_new, cnt loads LOAD_USE_STALL-1; otherwise a nonzero cnt decrements each cycle.
  - Total stall equals exactly LOAD_USE_STALL cycles.
- Handshake:
  - InReady = !stall & (OutReady | !OutValid).
- ID/EX register:
  - Loads when OutReady | !OutValid.
  - OutValid becomes InValid & !stall & !Flush.
  - On a bubble, OutCtrl is 0 and the data fields are don't-care; OutValid=0 is the qualifier.
  - When OutValid & !OutReady, all outputs hold and InReady=0.
- Flush:
  - Overrides stall, clears cnt, and suppresses BranchTaken.
  - A flush arriving mid-stall inserts a bubble the next cycle.
- Simultaneous events:
  - A writeback to the same register as a read in the same cycle returns the new data.
  - An EX forward beats the WB bypass.

Optional Feature:
- Macro: DECODE_DEBUG_EN.
- When defined:
  - Adds outputs v0, v1 (XLEN each), giving direct register 2/3 contents, write-through applied.
  - Adds StallCycles (32 bits), a saturating count of cycles with stall=1, reset to 0.
- When undefined: these ports and their logic are absent; no other behaviour changes.

Test Plan:
1. Reset low mid-stream with OutValid=1 → all outputs 0 immediately (asynchronous); on release, register 5 reads 0.
2. WbWrite reg 8 = 0x1234 while reading rs=8 in the same cycle → OutData1 = 0x1234 next edge; writes to reg 0 with 0xFFFF → reads 0.
3. Load to reg 9 in EX, ID instruction uses rt=9, LOAD_USE_STALL=1 → InReady=0 for one cycle and one bubble (OutValid=0, OutCtrl=0); instruction issues on the following cycle.
4. Repeat 3 with LOAD_USE_STALL=3 → exactly 3 stall cycles; assert Flush in stall cycle 2 → cnt cleared, bubble out, no BranchTaken.
5. beq with rs = rt = 0x10 (EX forward on rs), PC=0x100, imm=0xFFFE → BranchTaken=1 and BranchAddress=0xFC in the accept cycle; bltz with rs=0x80000000 → taken; bgtz with rs=0 → not taken.
6. OutReady=0 for 4 cycles with OutValid=1 → outputs stable, InReady=0; release → next instruction loads on the first ready edge.
